// File: rtl/alu_seq_pkg.sv
// Shared types and 74181 S-code constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_S_ADD = 4'b1001;
  localparam logic [3:0] ALU_S_SUB = 4'b0110;
  localparam logic [3:0] ALU_S_AND = 4'b1011;
  localparam logic [3:0] ALU_S_OR  = 4'b1110;
  // Same code as SUB; selects XOR when used with op_m = 1.
  localparam logic [3:0] ALU_S_XOR = 4'b0110;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bus between the CPU control unit and the nibble-serial ALU sequencer.
interface alu_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       op_s;
  logic             op_m;
  logic             carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             half_carry;
  logic             zero;

  modport master (
    output req_valid, op_s, op_m, carry_in, a, b, rsp_ready,
    input  req_ready, rsp_valid, result, carry_out, half_carry, zero
  );

  modport slave (
    input  req_valid, op_s, op_m, carry_in, a, b, rsp_ready,
    output req_ready, rsp_valid, result, carry_out, half_carry, zero
  );
endinterface

// File: rtl/Circuit74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data; CNb/CN4b are active-low carries.
module Circuit74181 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] S,
  input  logic       M,
  input  logic       CNb,
  output logic [3:0] F,
  output logic       X,
  output logic       Y,
  output logic       AEB,
  output logic       CN4b
);
  logic [3:0] or_t;
  logic [3:0] and_t;
  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] c;

  // Arithmetic result is or_t + and_t + cin; logic result is their XNOR.
  assign or_t  = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
  assign and_t = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});
  assign gen   = or_t & and_t;
  assign prop  = or_t | and_t;

  assign c[0] = ~CNb;
  assign c[1] = gen[0] | (prop[0] & c[0]);
  assign c[2] = gen[1] | (prop[1] & c[1]);
  assign c[3] = gen[2] | (prop[2] & c[2]);
  assign c[4] = gen[3] | (prop[3] & c[3]);

  assign F    = M ? ~(or_t ^ and_t) : (or_t ^ and_t ^ c[3:0]);
  assign CN4b = ~c[4];
  assign X    = ~(&prop);
  assign Y    = ~(gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1]) |
                  (prop[3] & prop[2] & prop[1] & gen[0]));
  assign AEB  = |F;
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH-bit ALU operation through one shared 74181 slice, one nibble per clock, LSB first.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_nibble_sequencer_if.slave bus
);
  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t state_q, state_d;

  logic [N-1:0][3:0] a_q;
  logic [N-1:0][3:0] b_q;
  logic [N-1:0][3:0] result_q;
  logic [3:0]        op_s_q;
  logic              op_m_q;
  logic              cnb_q;
  logic [IW-1:0]     idx_q;
  logic              zacc_q;
  logic              carry_q;
  logic              half_q;

  logic [3:0] slice_f;
  logic       slice_aeb;
  logic       slice_cn4b;
  logic       slice_x_unused;
  logic       slice_y_unused;

  Circuit74181 u_slice (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .S    (op_s_q),
    .M    (op_m_q),
    .CNb  (cnb_q),
    .F    (slice_f),
    .X    (slice_x_unused),
    .Y    (slice_y_unused),
    .AEB  (slice_aeb),
    .CN4b (slice_cn4b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_s_q   <= '0;
      op_m_q   <= 1'b0;
      cnb_q    <= 1'b1;
      idx_q    <= '0;
      zacc_q   <= 1'b0;
      carry_q  <= 1'b0;
      half_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_s_q   <= bus.op_s;
            op_m_q   <= bus.op_m;
            cnb_q    <= ~bus.carry_in;
            idx_q    <= '0;
            zacc_q   <= 1'b0;
            result_q <= '0;
          end
        end
        RUN: begin
          result_q[idx_q] <= slice_f;
          cnb_q           <= slice_cn4b;
          zacc_q          <= zacc_q | slice_aeb;
          idx_q           <= idx_q + IW'(1);
          // Carries are meaningless in logic mode, so report them as 0.
          if (idx_q == '0) half_q <= ~slice_cn4b & ~op_m_q;
          if (idx_q == LAST_IDX) carry_q <= ~slice_cn4b & ~op_m_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.carry_out  = carry_q;
  assign bus.half_carry = half_q;
  assign bus.zero       = (state_q == DONE) & ~zacc_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench: 8-bit and 16-bit sequencers with hand-computed expected results.
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  logic clk;
  logic reset;
  int   ncmp;
  int   nfail;

  alu_nibble_sequencer_if #(.WIDTH(8))  bus8 ();
  alu_nibble_sequencer_if #(.WIDTH(16)) bus16 ();

  alu_nibble_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  alu_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept, check the N=2 latency and the response; handshake unless hold is set.
  task automatic op8(input string tag, input logic [3:0] s, input logic m, input logic cin,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                     input logic ec, input logic eh, input logic ez, input bit hold);
    bus8.op_s      = s;
    bus8.op_m      = m;
    bus8.carry_in  = cin;
    bus8.a         = a;
    bus8.b         = b;
    bus8.req_valid = 1'b1;
    check({tag, " req_ready idle"}, bus8.req_ready, 1);
    tick();
    bus8.req_valid = 1'b0;
    check({tag, " req_ready run"}, bus8.req_ready, 0);
    check({tag, " rsp_valid e0+1"}, bus8.rsp_valid, 0);
    tick();
    check({tag, " rsp_valid e0+1 edge"}, bus8.rsp_valid, 0);
    tick();
    check({tag, " rsp_valid e0+2"}, bus8.rsp_valid, 1);
    check({tag, " result"}, bus8.result, er);
    check({tag, " carry_out"}, bus8.carry_out, ec);
    check({tag, " half_carry"}, bus8.half_carry, eh);
    check({tag, " zero"}, bus8.zero, ez);
    if (!hold) begin
      bus8.rsp_ready = 1'b1;
      tick();
      bus8.rsp_ready = 1'b0;
      check({tag, " req_ready after hs"}, bus8.req_ready, 1);
      check({tag, " rsp_valid after hs"}, bus8.rsp_valid, 0);
    end
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    reset = 1'b1;
    bus8.req_valid  = 1'b0;
    bus8.rsp_ready  = 1'b0;
    bus8.op_s       = '0;
    bus8.op_m       = 1'b0;
    bus8.carry_in   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus16.req_valid = 1'b0;
    bus16.rsp_ready = 1'b0;
    bus16.op_s      = '0;
    bus16.op_m      = 1'b0;
    bus16.carry_in  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    #1;
    check("reset req_ready", bus8.req_ready, 1);
    check("reset rsp_valid", bus8.rsp_valid, 0);
    check("reset result", bus8.result, 0);
    check("reset carry_out", bus8.carry_out, 0);
    check("reset half_carry", bus8.half_carry, 0);
    check("reset zero", bus8.zero, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    op8("add", ALU_S_ADD, 1'b0, 1'b0, 8'h3C, 8'h4F, 8'h8B, 1'b0, 1'b1, 1'b0, 1'b0);
    op8("ovf", ALU_S_ADD, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    op8("sub_eq", ALU_S_SUB, 1'b0, 1'b1, 8'h37, 8'h37, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    op8("sub_brw", ALU_S_SUB, 1'b0, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    op8("and", ALU_S_AND, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    op8("or", ALU_S_OR, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);
    op8("xor", ALU_S_XOR, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: DONE held for 5 cycles with a stray request pulse in the middle.
    op8("bp", ALU_S_ADD, 1'b0, 1'b0, 8'h3C, 8'h4F, 8'h8B, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus8.req_valid = (i == 2);
      bus8.a         = 8'h11;
      tick();
      check("bp rsp_valid", bus8.rsp_valid, 1);
      check("bp req_ready", bus8.req_ready, 0);
      check("bp result", bus8.result, 8'h8B);
      check("bp flags", {bus8.carry_out, bus8.half_carry, bus8.zero}, 3'b010);
    end
    bus8.req_valid = 1'b0;
    bus8.rsp_ready = 1'b1;
    tick();
    bus8.rsp_ready = 1'b0;
    check("bp req_ready after hs", bus8.req_ready, 1);
    check("bp rsp_valid after hs", bus8.rsp_valid, 0);
    tick();
    check("bp pulse ignored", bus8.req_ready, 1);
    check("bp result held", bus8.result, 8'h8B);

    // Reset in the middle of RUN: low nibble already written, then aborted.
    bus8.op_s      = ALU_S_ADD;
    bus8.op_m      = 1'b0;
    bus8.carry_in  = 1'b0;
    bus8.a         = 8'h3C;
    bus8.b         = 8'h4F;
    bus8.req_valid = 1'b1;
    tick();
    bus8.req_valid = 1'b0;
    tick();
    check("mid-run partial result", bus8.result, 8'h0B);
    reset = 1'b1;
    #1;
    check("abort req_ready", bus8.req_ready, 1);
    check("abort rsp_valid", bus8.rsp_valid, 0);
    check("abort result", bus8.result, 0);
    check("abort flags", {bus8.carry_out, bus8.half_carry, bus8.zero}, 3'b000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("abort no response", bus8.rsp_valid, 0);

    // 16-bit: four RUN edges.
    bus16.op_s      = ALU_S_ADD;
    bus16.op_m      = 1'b0;
    bus16.carry_in  = 1'b0;
    bus16.a         = 16'hFFFF;
    bus16.b         = 16'h0001;
    bus16.req_valid = 1'b1;
    check("w16 req_ready", bus16.req_ready, 1);
    tick();
    bus16.req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("w16 rsp_valid early", bus16.rsp_valid, 0);
    end
    tick();
    check("w16 rsp_valid", bus16.rsp_valid, 1);
    check("w16 result", bus16.result, 16'h0000);
    check("w16 carry_out", bus16.carry_out, 1);
    check("w16 half_carry", bus16.half_carry, 1);
    check("w16 zero", bus16.zero, 1);
    bus16.rsp_ready = 1'b1;
    tick();
    bus16.rsp_ready = 1'b0;
    check("w16 req_ready after hs", bus16.req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
